// File: rtl/vertex_transform_if.sv
// rtl/vertex_transform_if.sv - matrix load, vertex input and result handshake bundle for vertex_transform
interface vertex_transform_if #(
  parameter int DW = 21
);
  logic             mat_valid;
  logic [16*DW-1:0] mat_in;
  logic             mat_ready;
  logic             in_valid;
  logic [4*DW-1:0]  in_vtx;
  logic             in_ready;
  logic             out_valid;
  logic [4*DW-1:0]  out_vtx;
  logic             out_sat;
  logic             out_ready;

  modport master (
    output mat_valid, mat_in, in_valid, in_vtx, out_ready,
    input  mat_ready, in_ready, out_valid, out_vtx, out_sat
  );

  modport slave (
    input  mat_valid, mat_in, in_valid, in_vtx, out_ready,
    output mat_ready, in_ready, out_valid, out_vtx, out_sat
  );
endinterface

// File: rtl/vertex_transform.sv
// rtl/vertex_transform.sv - 4x4 Q1.10.10 matrix times homogeneous vertex, one row per cycle, saturating
module vertex_transform #(
  parameter int DW   = 21,
  parameter int FRAC = 10
) (
  input  logic               CLK,
  input  logic               rst,
  vertex_transform_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SW = 2*DW + 2;
  localparam logic [DW-1:0] ONE = DW'(1) << FRAC;
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DW-1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);

  logic [1:0]               state;
  logic [1:0]               cnt;
  logic signed [DW-1:0]     mat [16];
  logic signed [DW-1:0]     vtx [4];
  logic signed [DW-1:0]     res [4];
  logic                     sat_acc;
  logic                     out_valid_q;
  logic [4*DW-1:0]          out_vtx_q;
  logic                     out_sat_q;

  logic signed [DW-1:0]     mrow [4];
  logic signed [2*DW-1:0]   prod [4];
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     shifted;
  logic [DW-1:0]            row_res;
  logic                     row_sat;

  // Intermediates keep full precision; only the realigned row sum is clamped.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mrow[k] = mat[{cnt, 2'(k)}];
      prod[k] = (2*DW)'(mrow[k]) * (2*DW)'(vtx[k]);
    end
    sum     = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) + SW'(prod[3]);
    shifted = sum >>> FRAC;
    row_sat = 1'b0;
    if (shifted > SAT_HI) begin
      row_res = {1'b0, {(DW-1){1'b1}}};
      row_sat = 1'b1;
    end else if (shifted < SAT_LO) begin
      row_res = {1'b1, {(DW-1){1'b0}}};
      row_sat = 1'b1;
    end else begin
      row_res = shifted[DW-1:0];
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      sat_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      out_vtx_q   <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < 16; i++) mat[i] <= (i % 5 == 0) ? ONE : '0;
      for (int i = 0; i < 4; i++) begin
        vtx[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A matrix arriving with a vertex lands first, so CALC sees the new matrix.
          if (bus.mat_valid) begin
            for (int i = 0; i < 16; i++) mat[i] <= bus.mat_in[(15-i)*DW +: DW];
          end
          if (bus.in_valid) begin
            for (int i = 0; i < 4; i++) vtx[i] <= bus.in_vtx[(3-i)*DW +: DW];
            cnt     <= 2'd0;
            sat_acc <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          res[cnt] <= row_res;
          sat_acc  <= sat_acc | row_sat;
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_vtx_q   <= {res[0], res[1], res[2], res[3]};
            out_sat_q   <= sat_acc;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mat_ready = (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_vtx   = out_vtx_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_vertex_transform.sv
// tb/tb_vertex_transform.sv - randomized self-checking bench for vertex_transform against an arithmetic model
module tb_vertex_transform;
  localparam logic [20:0] ONE = 21'h000400;

  logic CLK;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [335:0] model_m;
  logic [335:0] ident;
  logic [84:0]  exp_res;
  logic [83:0]  held_vtx;
  int           lat;

  vertex_transform_if #(.DW(21)) bus ();

  vertex_transform #(.DW(21), .FRAC(10)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [335:0] put(input logic [335:0] m, input int idx, input logic [20:0] val);
    logic [335:0] r;
    r = m;
    r[(15-idx)*21 +: 21] = val;
    return r;
  endfunction

  function automatic logic [335:0] diag(input logic [20:0] a, input logic [20:0] b,
                                        input logic [20:0] c, input logic [20:0] d);
    logic [335:0] r;
    r = '0;
    r = put(r, 0, a);
    r = put(r, 5, b);
    r = put(r, 10, c);
    r = put(r, 15, d);
    return r;
  endfunction

  function automatic logic [83:0] vec(input logic [20:0] x, input logic [20:0] y,
                                      input logic [20:0] z, input logic [20:0] w);
    return {x, y, z, w};
  endfunction

  // Reference: exact integer dot products, floor division by 2^10, clamp to 21-bit signed.
  function automatic logic [84:0] model(input logic [335:0] m, input logic [83:0] v);
    logic [83:0]  out;
    logic         sat;
    logic [20:0]  e;
    longint       sum;
    longint       q;
    longint       a;
    longint       b;
    out = '0;
    sat = 1'b0;
    for (int r = 0; r < 4; r++) begin
      sum = 0;
      for (int c = 0; c < 4; c++) begin
        e = m[(15-(r*4+c))*21 +: 21];
        a = longint'($signed(e));
        e = v[(3-c)*21 +: 21];
        b = longint'($signed(e));
        sum += a * b;
      end
      q = sum >>> 10;
      if (q > 64'sd1048575) begin
        e = 21'h0FFFFF;
        sat = 1'b1;
      end else if (q < -64'sd1048576) begin
        e = 21'h100000;
        sat = 1'b1;
      end else begin
        e = q[20:0];
      end
      out[(3-r)*21 +: 21] = e;
    end
    return {sat, out};
  endfunction

  task automatic send(input logic [83:0] v, input bit load, input logic [335:0] m);
    @(negedge CLK);
    bus.in_vtx    = v;
    bus.in_valid  = 1'b1;
    bus.mat_in    = m;
    bus.mat_valid = load;
    @(posedge CLK);
    #1;
    bus.in_valid  = 1'b0;
    bus.mat_valid = 1'b0;
    if (load) model_m = m;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input int stall);
    logic [83:0] snap;
    snap = bus.out_vtx;
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK);
      #1;
      check("stall_valid", 128'(bus.out_valid), 128'(1));
      check("stall_vtx", 128'(bus.out_vtx), 128'(snap));
    end
    @(negedge CLK);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    check("hs_valid_low", 128'(bus.out_valid), 128'(0));
    check("hs_in_ready", 128'(bus.in_ready), 128'(1));
    check("hs_vtx_kept", 128'(bus.out_vtx), 128'(snap));
  endtask

  initial begin
    ident         = diag(ONE, ONE, ONE, ONE);
    model_m       = ident;
    rst           = 1'b0;
    bus.mat_valid = 1'b0;
    bus.mat_in    = '0;
    bus.in_valid  = 1'b0;
    bus.in_vtx    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_vtx", 128'(bus.out_vtx), 128'(0));
    check("rst_out_sat", 128'(bus.out_sat), 128'(0));
    @(negedge CLK);
    rst = 1'b1;
    #1;
    check("rst_mat_ready", 128'(bus.mat_ready), 128'(1));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));

    send(vec(21'h000400, 21'h000800, 21'h000C00, 21'h000400), 1'b0, '0);
    check("ident_latency", 128'(lat), 128'(5));
    check("ident_vtx", 128'(bus.out_vtx), 128'(vec(21'h000400, 21'h000800, 21'h000C00, 21'h000400)));
    check("ident_sat", 128'(bus.out_sat), 128'(0));
    handshake(0);

    send(vec(21'h000400, 21'h000800, 21'h000C00, 21'h000400), 1'b1,
         put(put(diag(21'h0, ONE, 21'h0, ONE), 2, ONE), 8, 21'h1FFC00));
    check("roty_vtx", 128'(bus.out_vtx), 128'(vec(21'h000C00, 21'h000800, 21'h1FFC00, 21'h000400)));
    check("roty_sat", 128'(bus.out_sat), 128'(0));
    handshake(1);

    send(vec(21'h001000, ONE, ONE, ONE), 1'b1, diag(21'h080000, ONE, ONE, ONE));
    check("satp_x", 128'(bus.out_vtx[83:63]), 128'(21'h0FFFFF));
    check("satp_flag", 128'(bus.out_sat), 128'(1));
    handshake(0);
    send(vec(21'h1FF000, ONE, ONE, ONE), 1'b0, '0);
    check("satn_x", 128'(bus.out_vtx[83:63]), 128'(21'h100000));
    check("satn_flag", 128'(bus.out_sat), 128'(1));
    handshake(0);

    // Backpressure: strobes toggled during DONE must be ignored.
    send(vec(ONE, 21'h000800, 21'h1FF800, ONE), 1'b1, diag(ONE, ONE, ONE, ONE));
    held_vtx = bus.out_vtx;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      bus.mat_valid = i[0];
      bus.in_valid  = ~i[0];
      bus.mat_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom[15:0]};
      bus.in_vtx    = {$urandom, $urandom, $urandom[19:0]};
      @(posedge CLK);
      #1;
      check("bp_valid", 128'(bus.out_valid), 128'(1));
      check("bp_vtx", 128'(bus.out_vtx), 128'(held_vtx));
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
      check("bp_mat_ready", 128'(bus.mat_ready), 128'(0));
    end
    bus.mat_valid = 1'b0;
    bus.in_valid  = 1'b0;
    handshake(0);
    send(vec(21'h000C00, 21'h1FF400, 21'h000400, ONE), 1'b0, '0);
    check("bp_mat_unchanged", 128'(bus.out_vtx), 128'(vec(21'h000C00, 21'h1FF400, 21'h000400, ONE)));
    handshake(0);

    send(vec(ONE, ONE, ONE, ONE), 1'b1, diag(21'h000800, 21'h000800, 21'h000800, 21'h000800));
    check("simul_vtx", 128'(bus.out_vtx), 128'(vec(21'h000800, 21'h000800, 21'h000800, 21'h000800)));
    handshake(0);

    // Reset asserted while row 2 is being computed.
    @(negedge CLK);
    bus.in_vtx   = vec(21'h000800, 21'h000800, 21'h000800, 21'h000800);
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_vtx", 128'(bus.out_vtx), 128'(0));
    model_m = ident;
    @(negedge CLK);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    send(vec(21'h000400, 21'h1FF800, 21'h000C00, 21'h000400), 1'b0, '0);
    check("midrst_ident", 128'(bus.out_vtx), 128'(vec(21'h000400, 21'h1FF800, 21'h000C00, 21'h000400)));
    handshake(0);

    for (int t = 0; t < 40; t++) begin
      logic [335:0] m;
      logic [83:0]  v;
      bit           load;
      for (int i = 0; i < 16; i++) begin
        if (t % 3 == 0) m = put(m, i, 21'($urandom));
        else            m = put(m, i, 21'($signed(12'($urandom))) <<< 2);
      end
      for (int i = 0; i < 4; i++) begin
        if (t % 4 == 1) v[(3-i)*21 +: 21] = 21'($urandom);
        else            v[(3-i)*21 +: 21] = 21'($signed(14'($urandom))) <<< 2;
      end
      load = ($urandom_range(0, 2) != 0);
      send(v, load, m);
      exp_res = model(model_m, v);
      check("rnd_latency", 128'(lat), 128'(5));
      check("rnd_vtx", 128'(bus.out_vtx), 128'(exp_res[83:0]));
      check("rnd_sat", 128'(bus.out_sat), 128'(exp_res[84]));
      handshake($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
